// File: rtl/bytes_to_bits_stream.sv
// Repacks a byte stream into LSB-first fields of run-time width d (1..OUT_BITS).
// Frames are started by a one-cycle start pulse that latches len and d.
module bytes_to_bits_stream #(
    parameter  int IN_BYTES = 1,
    parameter  int OUT_BITS = 12,
    parameter  int MAX_LEN  = 384,
    localparam int LEN_W    = $clog2(MAX_LEN) + 1,
    localparam int DW       = $clog2(OUT_BITS) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      len,
    input  logic [DW-1:0]         d,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*IN_BYTES-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_BITS-1:0]   out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int ACC_W = OUT_BITS + 8 * IN_BYTES;
    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam logic [OUT_BITS-1:0] ONES = '1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   left_q, left_d;
    logic [DW-1:0]      dw_q, dw_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cfg_err_q, cfg_err_d;

    logic               run, has_field, frame_end, start_bad;
    logic [CNT_W-1:0]   dw_ext;
    logic [LEN_W-1:0]   n_take;
    logic [ACC_W-1:0]   beat;

    assign run       = (state_q == RUN);
    assign dw_ext    = CNT_W'(dw_q);
    assign has_field = (cnt_q >= dw_ext);
    assign frame_end = run && (left_q == '0) && !has_field;
    assign start_bad = (d == '0) || (d > DW'(OUT_BITS)) || (len > LEN_W'(MAX_LEN));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            left_q    <= '0;
            dw_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            left_q    <= left_d;
            dw_q      <= dw_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start && !start_bad) state_d = RUN;
            RUN:  if (frame_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = run && (left_q != '0) && !has_field;
        out_valid = run && has_field;
        out_last  = out_valid && (left_q == '0) && ((cnt_q - dw_ext) < dw_ext);
        out_data  = acc_q[OUT_BITS-1:0] & ~(ONES << dw_q);
        busy      = run;
        done      = frame_end || cfg_err_q;
        err       = cfg_err_q;
    end

    // Only bytes still owed to the frame are merged; surplus beat lanes are masked off.
    always_comb begin
        n_take = (left_q < LEN_W'(IN_BYTES)) ? left_q : LEN_W'(IN_BYTES);
        beat   = '0;
        for (int unsigned k = 0; k < IN_BYTES; k++) begin
            if (LEN_W'(k) < n_take) beat[8*k +: 8] = in_data[8*k +: 8];
        end
    end

    always_comb begin
        left_d    = left_q;
        dw_d      = dw_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        cfg_err_d = 1'b0;
        if (state_q == IDLE) begin
            if (start && start_bad) begin
                cfg_err_d = 1'b1;
            end else if (start) begin
                left_d = len;
                dw_d   = d;
                acc_d  = '0;
                cnt_d  = '0;
            end
        end else if (frame_end) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (in_valid && in_ready) begin
            acc_d  = acc_q | (beat << cnt_q);
            cnt_d  = cnt_q + CNT_W'({n_take, 3'b000});
            left_d = left_q - n_take;
        end else if (out_valid && out_ready) begin
            acc_d = acc_q >> dw_q;
            cnt_d = cnt_q - dw_ext;
        end
    end
endmodule

// File: tb/tb_bytes_to_bits_stream.sv
// Directed bench for bytes_to_bits_stream with default parameters (1 byte/beat, 12-bit fields).
module tb_bytes_to_bits_stream;
    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_ready, out_valid, out_ready, out_last, busy, done, err;
    logic [9:0]  len;
    logic [4:0]  d;
    logic [7:0]  in_data;
    logic [11:0] out_data;

    int tests = 0;
    int fails = 0;

    logic [7:0]  tx_q[$];
    logic [11:0] f_data[$];
    logic        f_last[$];
    int done_cnt, err_cnt, done_cyc, last_out_cyc, stall_bad, both_bad, taken;
    bit timed_out;

    bytes_to_bits_stream #(.IN_BYTES(1), .OUT_BITS(12), .MAX_LEN(384)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .d(d),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [9:0] l, input logic [4:0] dd);
        start = 1'b1;
        len   = l;
        d     = dd;
        tick();
        start = 1'b0;
    endtask

    // Feeds tx_q and collects fields until done; stall_at >= 0 holds out_ready low 3 cycles on that field.
    task automatic run_frame(input int stall_at, input int budget);
        int idx = 0;
        int stall_left = 0;
        bit stall_started = 0;
        logic [11:0] held = '0;
        f_data.delete();
        f_last.delete();
        done_cnt = 0; err_cnt = 0; done_cyc = -1; last_out_cyc = -1;
        stall_bad = 0; both_bad = 0; taken = 0; timed_out = 1'b1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            in_valid = (idx < tx_q.size());
            in_data  = in_valid ? tx_q[idx] : 8'h00;
            if (stall_at >= 0 && !stall_started && out_valid && f_data.size() == stall_at) begin
                stall_started = 1;
                stall_left = 3;
                held = out_data;
            end
            out_ready = (stall_left == 0);
            if (stall_left > 0) begin
                if (out_data !== held || in_ready !== 1'b0 || out_valid !== 1'b1) stall_bad++;
                stall_left--;
            end
            if (in_ready === 1'b1 && out_valid === 1'b1) both_bad++;
            if (out_valid && out_ready) begin
                f_data.push_back(out_data);
                f_last.push_back(out_last);
                last_out_cyc = cyc;
            end
            if (in_valid && in_ready) begin
                idx++;
                taken++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                if (err === 1'b1) err_cnt++;
            end
            tick();
            if (done_cnt != 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests++;
        if ({in_ready, out_valid, out_last, busy, done, err, out_data} !== 18'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %b required 0", {in_ready, out_valid, out_last, busy, done, err, out_data});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_d8();
        logic [11:0] exp_f[2] = '{12'h0A5, 12'h03C};
        logic        exp_l[2] = '{1'b0, 1'b1};
        tx_q = '{8'hA5, 8'h3C};
        do_start(10'd2, 5'd8);
        run_frame(-1, 60);
        tests++;
        if (timed_out || f_data.size() != 2) begin
            fails++;
            $display("FAIL d8_count: got %0d fields (timeout=%0b) required 2", f_data.size(), timed_out);
        end
        for (int i = 0; i < 2 && i < f_data.size(); i++) begin
            tests++;
            if (f_data[i] !== exp_f[i] || f_last[i] !== exp_l[i]) begin
                fails++;
                $display("FAIL d8_field%0d: got %h/last %b required %h/last %b", i, f_data[i], f_last[i], exp_f[i], exp_l[i]);
            end
        end
        tests++;
        if (done_cyc != last_out_cyc + 1 || err_cnt != 0 || both_bad != 0) begin
            fails++;
            $display("FAIL d8_done: got done_cyc %0d err %0d both %0d required %0d 0 0", done_cyc, err_cnt, both_bad, last_out_cyc + 1);
        end
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL d8_after: got done %b busy %b required 0 0", done, busy);
        end
    endtask

    task automatic test_d12();
        logic [11:0] exp_f[2] = '{12'h301, 12'h452};
        logic        exp_l[2] = '{1'b0, 1'b1};
        tx_q = '{8'h01, 8'h23, 8'h45};
        do_start(10'd3, 5'd12);
        run_frame(-1, 60);
        tests++;
        if (timed_out || f_data.size() != 2 || err_cnt != 0) begin
            fails++;
            $display("FAIL d12_count: got %0d fields err %0d (timeout=%0b) required 2 0", f_data.size(), err_cnt, timed_out);
        end
        for (int i = 0; i < 2 && i < f_data.size(); i++) begin
            tests++;
            if (f_data[i] !== exp_f[i] || f_last[i] !== exp_l[i]) begin
                fails++;
                $display("FAIL d12_field%0d: got %h/last %b required %h/last %b", i, f_data[i], f_last[i], exp_f[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_d1();
        logic [7:0] got_bits = '0;
        logic [7:0] got_last = '0;
        tx_q = '{8'h81};
        do_start(10'd1, 5'd1);
        run_frame(-1, 60);
        for (int i = 0; i < 8 && i < f_data.size(); i++) begin
            got_bits[i] = f_data[i][0];
            got_last[i] = f_last[i];
        end
        tests++;
        if (timed_out || f_data.size() != 8) begin
            fails++;
            $display("FAIL d1_count: got %0d fields (timeout=%0b) required 8", f_data.size(), timed_out);
        end
        tests++;
        if (got_bits !== 8'b1000_0001 || got_last !== 8'b1000_0000) begin
            fails++;
            $display("FAIL d1_fields: got bits %b last %b required 10000001 10000000", got_bits, got_last);
        end
    endtask

    task automatic test_stall();
        tx_q = '{8'hFF, 8'hFF};
        do_start(10'd2, 5'd5);
        run_frame(1, 80);
        tests++;
        if (timed_out || f_data.size() != 3 || err_cnt != 0) begin
            fails++;
            $display("FAIL stall_count: got %0d fields err %0d (timeout=%0b) required 3 0", f_data.size(), err_cnt, timed_out);
        end
        for (int i = 0; i < 3 && i < f_data.size(); i++) begin
            tests++;
            if (f_data[i] !== 12'h01F || f_last[i] !== (i == 2)) begin
                fails++;
                $display("FAIL stall_field%0d: got %h/last %b required 01f/last %b", i, f_data[i], f_last[i], (i == 2));
            end
        end
        tests++;
        if (stall_bad != 0 || both_bad != 0) begin
            fails++;
            $display("FAIL stall_hold: got %0d unstable cycles, %0d overlap cycles required 0 0", stall_bad, both_bad);
        end
    endtask

    task automatic test_illegal();
        logic [9:0] bad_len[3] = '{10'd4, 10'd4, 10'd385};
        logic [4:0] bad_d[3]   = '{5'd0, 5'd13, 5'd8};
        for (int i = 0; i < 3; i++) begin
            do_start(bad_len[i], bad_d[i]);
            tests++;
            if (done !== 1'b1 || err !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL illegal%0d_pulse: got done %b err %b rdy %b busy %b required 1 1 0 0", i, done, err, in_ready, busy);
            end
            tick();
            tests++;
            if (done !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL illegal%0d_after: got done %b err %b rdy %b busy %b required 0 0 0 0", i, done, err, in_ready, busy);
            end
        end
    endtask

    task automatic test_len0();
        do_start(10'd0, 5'd8);
        tests++;
        if (done !== 1'b1 || err !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL len0_pulse: got done %b err %b ov %b rdy %b required 1 0 0 0", done, err, out_valid, in_ready);
        end
        tick();
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL len0_after: got done %b busy %b required 0 0", done, busy);
        end
    endtask

    task automatic test_short();
        tx_q = '{8'hFF};
        do_start(10'd1, 5'd12);
        run_frame(-1, 40);
        tests++;
        if (timed_out || f_data.size() != 0 || taken != 1 || err_cnt != 0) begin
            fails++;
            $display("FAIL short_frame: got %0d fields %0d bytes err %0d (timeout=%0b) required 0 1 0", f_data.size(), taken, err_cnt, timed_out);
        end
    endtask

    task automatic test_start_busy();
        tx_q = '{8'h5A};
        do_start(10'd1, 5'd8);
        do_start(10'd5, 5'd0);
        tests++;
        if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL busy_start: got busy %b done %b err %b required 1 0 0", busy, done, err);
        end
        run_frame(-1, 40);
        tests++;
        if (timed_out || f_data.size() != 1 || err_cnt != 0 || (f_data.size() == 1 && (f_data[0] !== 12'h05A || f_last[0] !== 1'b1))) begin
            fails++;
            $display("FAIL busy_frame: got %0d fields first %h err %0d required 1 05a 0", f_data.size(), (f_data.size() > 0) ? f_data[0] : 12'hxxx, err_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        int bad_done = 0;
        do_start(10'd3, 5'd12);
        in_valid = 1'b1;
        in_data  = 8'h01;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_ready: got %b required 1", in_ready);
        end
        tick();
        rst     = 1'b1;
        in_data = 8'h23;
        tick();
        tests++;
        if ({in_ready, out_valid, out_last, busy, done, err, out_data} !== 18'h0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got %b required 0", {in_ready, out_valid, out_last, busy, done, err, out_data});
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) bad_done++;
        end
        tests++;
        if (bad_done != 0) begin
            fails++;
            $display("FAIL mid_no_done: got %0d cycles with done/busy required 0", bad_done);
        end
        test_d12();
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; len = '0; d = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #1;
        test_reset();
        test_d8();
        test_d12();
        test_d1();
        test_stall();
        test_illegal();
        test_len0();
        test_short();
        test_start_busy();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bytes_to_bits_stream.md
BYTES_TO_BITS_STREAM -- requirements
Module: bytes_to_bits_stream

Interface
REQ-001 SHALL have parameter IN_BYTES, default 1: bytes accepted per input beat.
REQ-002 SHALL have parameter OUT_BITS, default 12: maximum output field width d.
REQ-003 SHALL have parameter MAX_LEN, default 384: maximum frame length in bytes; LEN_W = $clog2(MAX_LEN)+1.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports as follows.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 start  input  1  one-cycle frame start; samples len and d.
REQ-008 len  input  LEN_W  frame length in bytes.
REQ-009 d  input  $clog2(OUT_BITS)+1  field width, legal range 1..OUT_BITS.
REQ-010 in_valid / in_ready  input / output  1 each  byte-beat handshake.
REQ-011 in_data  input  8*IN_BYTES  byte k occupies in_data[8k+7:8k]; byte 0 is first in stream order.
REQ-012 out_valid / out_ready  output / input  1 each  field handshake.
REQ-013 out_data  output  OUT_BITS  field value, zero-extended above bit d-1.
REQ-014 out_last  output  1  marks final field of frame.
REQ-015 busy, done, err  output  1 each  frame active; one-cycle completion pulse; illegal-config flag valid with done.

Function
REQ-016 SHALL order bits LSB-first: stream bit 8i+j = bit j of byte i; field n = stream bits [n*d+d-1 : n*d].
REQ-017 SHALL implement states IDLE and RUN; start in IDLE latches len/d, clears accumulator (width OUT_BITS+8*IN_BYTES) and bit count, enters RUN next cycle; start outside IDLE SHALL be ignored.
REQ-018 Start with d=0, d>OUT_BITS, or len>MAX_LEN SHALL consume no input, pulse done and err for one cycle, and stay IDLE.
REQ-019 Start with len=0 and legal d SHALL pulse done (err=0) on the following cycle with no output.
REQ-020 in_ready SHALL be 1 only in RUN when bytes_left>0 and bit_cnt<d.
REQ-021 On in_valid&&in_ready, min(IN_BYTES, bytes_left) bytes SHALL be appended at accumulator bit position bit_cnt; unused upper bytes ignored; bytes_left and bit_cnt update at that edge.
REQ-022 out_valid SHALL be 1 iff in RUN and bit_cnt>=d; out_data = acc[d-1:0] registered, with zero latency from accumulator state (first field valid the cycle after the filling beat).
REQ-023 On out_valid&&out_ready, accumulator SHALL shift right by d and bit_cnt decrease by d.
REQ-024 out_valid and in_ready SHALL never both be 1; out_data/out_last SHALL hold stable while out_valid&&!out_ready.
REQ-025 out_last SHALL be 1 with out_valid when bytes_left=0 and bit_cnt-d<d.
REQ-026 When in RUN, bytes_left=0 and bit_cnt<d, the block SHALL discard remaining bits, pulse done (err=0) for that cycle, and return to IDLE next cycle.
REQ-027 busy SHALL be 1 exactly while in RUN.
REQ-028 Frames with len*8<d SHALL consume all bytes, emit no field, and complete per REQ-026.

Reset
REQ-029 rst SHALL force IDLE, clear accumulator, counters, and latched len/d; in_ready, out_valid, out_last, busy, done, err, out_data SHALL all be 0 the cycle after rst.
REQ-030 rst mid-frame SHALL abort without done; input and output in flight are dropped; next start behaves as from power-up.

Verification
REQ-031 d=8, len=2, bytes 0xA5,0x3C -> out_data 0x0A5, 0x03C; out_last on second; done one cycle after its acceptance.
REQ-032 d=12, len=3, bytes 0x01,0x23,0x45 -> fields 0x301, 0x452; out_last on 0x452.
REQ-033 d=1, len=1, byte 0x81 -> eight fields 1,0,0,0,0,0,0,1; out_last on eighth.
REQ-034 d=5, len=2, bytes 0xFF,0xFF, out_ready low 3 cycles mid-frame -> fields 0x1F x3, out_data stable and in_ready=0 while stalled, last bit discarded, done.
REQ-035 start with d=0 -> done=1 and err=1 next cycle, in_ready never 1; start while busy ignored.
REQ-036 rst asserted after first accepted byte of d=12 frame -> all outputs 0 next cycle, no done; new frame per REQ-032 then passes.
